// File: rtl/uart_receiver.sv
// Oversampling UART receive path: 2-FF line synchronizer, start/data/stop FSM with
// break detection, and a valid/ack holding register with sticky overrun.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 tx_clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   sync_rx;
  logic                   load_good;
  logic                   stop_bad;

  assign sync_rx = sync_q[1];

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], rx_in};
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    load_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!sync_rx) state_d = START;
      end
      START: begin
        if (tick_q == TICK_MID) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = sync_rx ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_q == TICK_END) begin
          tick_d  = '0;
          // LSB arrives first, so each new bit enters at the top and walks down.
          shift_d = {sync_rx, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_q == TICK_END) begin
          tick_d = '0;
          if (sync_rx) begin
            load_good = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a long low is not read as new frames.
        if (sync_rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake: rx_valid means rx_data holds an unconsumed byte; a cycle with rx_ack=1
  // consumes it on the next edge. A byte landing in the ack cycle stays valid, and only
  // a landing while valid and unacked counts as overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = stop_bad;
    if (rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load_good) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) ovr_d = 1'b1;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks/bit, 8 data bits: frames are shifted in
// cycle by cycle and good bytes are scored against an expected queue.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          tx_clk;
  logic          reset;
  logic          rx_in;
  logic          rx_ack;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;
  logic [2:0]    state_dbg;

  int            checks = 0;
  int            errors = 0;
  int            ferr_cnt = 0;
  int            valid_at;
  int            busy_seen;
  int            ferr_base;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] exp_byte;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .tx_clk    (tx_clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  always @(negedge tx_clk) if (frame_err) ferr_cnt <= ferr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge tx_clk);
      rx_in  = 1'b1;
      rx_ack = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(negedge tx_clk);
    rx_ack = 1'b1;
    @(negedge tx_clk);
    rx_ack = 1'b0;
  endtask

  // Drives one frame; bits after the first n_cycles are not driven (used for aborts).
  // rx_ack is raised for the single cycle ack_at (-1 for none).
  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit,
                            input int ack_at, input int n_cycles);
    logic [DB+1:0] bits;
    bits = {stop_bit, data, 1'b0};
    if (stop_bit && n_cycles == (DB + 2) * OS) exp_q.push_back(data);
    valid_at  = -1;
    busy_seen = 0;
    for (int i = 0; i < n_cycles; i++) begin
      @(negedge tx_clk);
      if (rx_valid && valid_at < 0 && i > 0) valid_at = i;
      if (rx_busy) busy_seen = 1;
      rx_in  = bits[i / OS];
      rx_ack = (i == ack_at);
    end
  endtask

  task automatic score_byte(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_byte = exp_q.pop_front();
      check(tag, {24'd0, rx_data}, {24'd0, exp_byte});
    end
  endtask

  initial begin
    reset  = 1'b1;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge tx_clk);
    check("rst_data",  {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy",  {31'd0, rx_busy}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    idle_cycles(5);

    // 1: 0xA5, no ack
    ferr_base = ferr_cnt;
    send_frame(8'hA5, 1'b1, -1, (DB + 2) * OS);
    @(negedge tx_clk);
    check("t1_valid", {31'd0, rx_valid}, 32'd1);
    score_byte("t1_data");
    check("t1_latency_ok", {31'd0, (valid_at >= 150 && valid_at <= 160)}, 32'd1);
    check("t1_ferr", ferr_cnt - ferr_base, 32'd0);
    check("t1_ovr", {31'd0, overrun}, 32'd0);
    ack_pulse();
    check("t1_ack_valid", {31'd0, rx_valid}, 32'd0);
    rx_ack = 1'b1;  // ack with nothing pending is ignored
    idle_cycles(4);
    check("t1_idle_valid", {31'd0, rx_valid}, 32'd0);

    // 2: 4-clock glitch is a false start
    ferr_base = ferr_cnt;
    send_frame(8'h00, 1'b1, -1, 4);
    idle_cycles(20);
    check("t2_was_busy", busy_seen | {31'd0, rx_busy}, 32'd1);
    check("t2_busy", {31'd0, rx_busy}, 32'd0);
    check("t2_valid", {31'd0, rx_valid}, 32'd0);
    check("t2_ferr", ferr_cnt - ferr_base, 32'd0);

    // 3: 0x3C with bad stop, line held low, then released
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, (DB + 2) * OS);
    for (int i = 0; i < 40; i++) begin
      @(negedge tx_clk);
      rx_in = 1'b0;
    end
    check("t3_ferr_once", ferr_cnt - ferr_base, 32'd1);
    check("t3_break", {29'd0, state_dbg}, {29'd0, ST_BREAK});
    check("t3_busy_in_break", {31'd0, rx_busy}, 32'd1);
    check("t3_valid", {31'd0, rx_valid}, 32'd0);
    idle_cycles(5);
    check("t3_idle", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("t3_ferr_total", ferr_cnt - ferr_base, 32'd1);

    // 4: 0x11 then 0x22 without ack -> overrun
    send_frame(8'h11, 1'b1, -1, (DB + 2) * OS);
    @(negedge tx_clk);
    score_byte("t4_data1");
    check("t4_ovr1", {31'd0, overrun}, 32'd0);
    idle_cycles(3);
    send_frame(8'h22, 1'b1, -1, (DB + 2) * OS);
    @(negedge tx_clk);
    score_byte("t4_data2");
    check("t4_valid", {31'd0, rx_valid}, 32'd1);
    check("t4_ovr2", {31'd0, overrun}, 32'd1);
    ack_pulse();
    check("t4_ack_valid", {31'd0, rx_valid}, 32'd0);
    check("t4_ack_ovr", {31'd0, overrun}, 32'd0);

    // 5: ack lands in the load cycle of 0x55 while 0x66 is pending
    idle_cycles(3);
    send_frame(8'h66, 1'b1, -1, (DB + 2) * OS);
    @(negedge tx_clk);
    score_byte("t5_data_prev");
    idle_cycles(3);
    send_frame(8'h55, 1'b1, 154, (DB + 2) * OS);
    @(negedge tx_clk);
    score_byte("t5_data");
    check("t5_valid", {31'd0, rx_valid}, 32'd1);
    check("t5_ovr", {31'd0, overrun}, 32'd0);
    ack_pulse();

    // 6: reset during data bit 4 of 0xF0, then 0x0F
    idle_cycles(3);
    send_frame(8'hF0, 1'b1, -1, 5 * OS + 8);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy",  {31'd0, rx_busy}, 32'd0);
    check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rst_data",  {24'd0, rx_data}, 32'd0);
    check("t6_rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("t6_rst_ovr",   {31'd0, overrun}, 32'd0);
    @(negedge tx_clk);
    rx_in = 1'b1;
    @(negedge tx_clk);
    reset = 1'b0;
    idle_cycles(20);
    check("t6_no_spurious", {31'd0, rx_valid}, 32'd0);
    ferr_base = ferr_cnt;
    send_frame(8'h0F, 1'b1, -1, (DB + 2) * OS);
    @(negedge tx_clk);
    score_byte("t6_data");
    check("t6_valid", {31'd0, rx_valid}, 32'd1);
    check("t6_ferr", ferr_cnt - ferr_base, 32'd0);

    // 7: a few random bytes, each acked
    for (int n = 0; n < 4; n++) begin
      ack_pulse();
      idle_cycles($urandom_range(1, 6));
      send_frame(8'($urandom_range(0, 255)), 1'b1, -1, (DB + 2) * OS);
      @(negedge tx_clk);
      score_byte("t7_data");
      check("t7_ovr", {31'd0, overrun}, 32'd0);
    end

    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
